// File: rtl/execute_pipe_if.sv
// execute_pipe_if: instruction handshake, operand/control inputs and the
// registered result bus of the execute stage.
interface execute_pipe_if #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    dato1;
    logic [WIDTH-1:0]    dato2;
    logic [WIDTH-1:0]    immediate;
    logic [WIDTH-1:0]    pc_plus4;
    logic [REG_ADDR-1:0] rt;
    logic [REG_ADDR-1:0] rd;
    logic [1:0]          ex;
    logic [2:0]          m;
    logic [2:0]          wb;
    logic [3:0]          alu_sel;
    logic                stall_in;
    logic                flush;
    logic                out_valid;
    logic [WIDTH-1:0]    alu_result;
    logic [WIDTH-1:0]    add_result;
    logic                zero;
    logic [WIDTH-1:0]    dato2_m;
    logic [REG_ADDR-1:0] direccion;
    logic [2:0]          m_out;
    logic [2:0]          wb_out;
    logic                busy;

    // upstream / environment side
    modport master (
        output in_valid, dato1, dato2, immediate, pc_plus4, rt, rd, ex, m, wb,
               alu_sel, stall_in, flush,
        input  in_ready, out_valid, alu_result, add_result, zero, dato2_m,
               direccion, m_out, wb_out, busy
    );

    // execute stage side
    modport slave (
        input  in_valid, dato1, dato2, immediate, pc_plus4, rt, rd, ex, m, wb,
               alu_sel, stall_in, flush,
        output in_ready, out_valid, alu_result, add_result, zero, dato2_m,
               direccion, m_out, wb_out, busy
    );
endinterface

// File: rtl/execute_pipe.sv
// execute_pipe: single-cycle ALU execute stage with registered outputs,
// stall/flush control and an optional shift-add multiplier.
// Optional feature macro: EXECUTE_PIPE_MULT_EN enables the multicycle MULT
// (alu_sel 1000), the MUL/WAIT states and the busy flag.
module execute_pipe #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input logic           clk,
    input logic           rst,
    execute_pipe_if.slave bus
);

`ifdef EXECUTE_PIPE_MULT_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, WAIT = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

    state_t              state_r;
    state_t              state_next_s;
    logic [WIDTH-1:0]    op_b_s;
    logic [WIDTH-1:0]    alu_s;
    logic [WIDTH-1:0]    add_s;
    logic [REG_ADDR-1:0] dir_s;
    logic                accept_s;
    logic                is_mul_s;
    logic                mul_load_s;
    logic                load_s;
    logic [WIDTH-1:0]    res_alu_s;
    logic [WIDTH-1:0]    res_add_s;
    logic [WIDTH-1:0]    res_dato2_s;
    logic [REG_ADDR-1:0] res_dir_s;
    logic [2:0]          res_m_s;
    logic [2:0]          res_wb_s;

    logic                out_valid_r;
    logic [WIDTH-1:0]    alu_result_r;
    logic [WIDTH-1:0]    add_result_r;
    logic                zero_r;
    logic [WIDTH-1:0]    dato2_m_r;
    logic [REG_ADDR-1:0] direccion_r;
    logic [2:0]          m_out_r;
    logic [2:0]          wb_out_r;

    // Single-cycle ALU; MULT is not handled here (multicycle path or undefined).
    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0]       sel,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (sel)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            4'b1100: r = ~(a | b);
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign op_b_s        = bus.ex[1] ? bus.immediate : bus.dato2;
    assign dir_s         = bus.ex[0] ? bus.rd : bus.rt;
    assign alu_s         = alu_f(bus.alu_sel, bus.dato1, op_b_s);
    assign add_s         = bus.pc_plus4 + (bus.immediate << 2);
    assign bus.in_ready  = (state_r == IDLE) && !bus.stall_in;
    assign accept_s      = bus.in_valid && bus.in_ready && !bus.flush;
    assign load_s        = (accept_s && !is_mul_s) || mul_load_s;

`ifdef EXECUTE_PIPE_MULT_EN
    logic [WIDTH-1:0]    mcand_r;
    logic [WIDTH-1:0]    mplier_r;
    logic [WIDTH-1:0]    acc_r;
    logic [WIDTH-1:0]    acc_next_s;
    logic [WIDTH-1:0]    mul_prod_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                fin_s;
    logic                busy_r;
    logic [WIDTH-1:0]    add_pend_r;
    logic [WIDTH-1:0]    dato2_pend_r;
    logic [REG_ADDR-1:0] dir_pend_r;
    logic [2:0]          m_pend_r;
    logic [2:0]          wb_pend_r;

    assign is_mul_s   = (bus.alu_sel == 4'b1000);
    assign fin_s      = (state_r == MUL) && (cnt_r == CNT_W'(WIDTH - 1));
    assign acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    // In WAIT the last iteration has already been folded into acc_r.
    assign mul_prod_s = (state_r == WAIT) ? acc_r : acc_next_s;
    assign mul_load_s = (fin_s || (state_r == WAIT)) && !bus.stall_in && !bus.flush;
    assign bus.busy   = busy_r;

    // Shift-add multiplier datapath and side-band capture for the pending MULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r      <= {WIDTH{1'b0}};
            mplier_r     <= {WIDTH{1'b0}};
            acc_r        <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            add_pend_r   <= {WIDTH{1'b0}};
            dato2_pend_r <= {WIDTH{1'b0}};
            dir_pend_r   <= {REG_ADDR{1'b0}};
            m_pend_r     <= 3'b000;
            wb_pend_r    <= 3'b000;
        end else if (accept_s && is_mul_s) begin
            mcand_r      <= bus.dato1;
            mplier_r     <= op_b_s;
            acc_r        <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            add_pend_r   <= add_s;
            dato2_pend_r <= bus.dato2;
            dir_pend_r   <= dir_s;
            m_pend_r     <= bus.m;
            wb_pend_r    <= bus.wb;
        end else if (state_r == MUL) begin
            mcand_r      <= mcand_r << 1;
            mplier_r     <= mplier_r >> 1;
            acc_r        <= acc_next_s;
            cnt_r        <= cnt_r + CNT_W'(1);
        end
    end

    // Next-state logic; flush aborts any multiply in progress.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_mul_s) state_next_s = MUL;
                else                      state_next_s = IDLE;
            end
            MUL: begin
                if (fin_s) state_next_s = bus.stall_in ? WAIT : IDLE;
                else       state_next_s = MUL;
            end
            WAIT: begin
                if (bus.stall_in) state_next_s = WAIT;
                else              state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
        if (bus.flush) state_next_s = IDLE;
        else           state_next_s = state_next_s;
    end

    // busy is registered from the next state so it tracks state_r exactly.
    always_ff @(posedge clk) begin
        if (rst) busy_r <= 1'b0;
        else     busy_r <= (state_next_s != IDLE);
    end

    // Result source: completed product with captured side-band, or direct path.
    always_comb begin
        if (mul_load_s) begin
            res_alu_s   = mul_prod_s;
            res_add_s   = add_pend_r;
            res_dato2_s = dato2_pend_r;
            res_dir_s   = dir_pend_r;
            res_m_s     = m_pend_r;
            res_wb_s    = wb_pend_r;
        end else begin
            res_alu_s   = alu_s;
            res_add_s   = add_s;
            res_dato2_s = bus.dato2;
            res_dir_s   = dir_s;
            res_m_s     = bus.m;
            res_wb_s    = bus.wb;
        end
    end
`else
    assign is_mul_s   = 1'b0;
    assign mul_load_s = 1'b0;
    assign bus.busy   = 1'b0;

    // Without the multiplier the stage never leaves IDLE.
    always_comb begin
        state_next_s = IDLE;
    end

    // Result source is always the single-cycle path.
    always_comb begin
        res_alu_s   = alu_s;
        res_add_s   = add_s;
        res_dato2_s = bus.dato2;
        res_dir_s   = dir_s;
        res_m_s     = bus.m;
        res_wb_s    = bus.wb;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Output register: reset clears all, flush kills control, stall holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            alu_result_r <= {WIDTH{1'b0}};
            add_result_r <= {WIDTH{1'b0}};
            zero_r       <= 1'b0;
            dato2_m_r    <= {WIDTH{1'b0}};
            direccion_r  <= {REG_ADDR{1'b0}};
            m_out_r      <= 3'b000;
            wb_out_r     <= 3'b000;
        end else if (bus.flush) begin
            out_valid_r  <= 1'b0;
            m_out_r      <= 3'b000;
            wb_out_r     <= 3'b000;
        end else if (!bus.stall_in) begin
            out_valid_r  <= load_s;
            if (load_s) begin
                alu_result_r <= res_alu_s;
                add_result_r <= res_add_s;
                zero_r       <= (res_alu_s == {WIDTH{1'b0}});
                dato2_m_r    <= res_dato2_s;
                direccion_r  <= res_dir_s;
                m_out_r      <= res_m_s;
                wb_out_r     <= res_wb_s;
            end
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.alu_result = alu_result_r;
    assign bus.add_result = add_result_r;
    assign bus.zero       = zero_r;
    assign bus.dato2_m    = dato2_m_r;
    assign bus.direccion  = direccion_r;
    assign bus.m_out      = m_out_r;
    assign bus.wb_out     = wb_out_r;

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed checks of the execute stage (WIDTH=32).
module tb_execute_pipe;
    localparam int W = 32;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    execute_pipe_if #(.WIDTH(W), .REG_ADDR(R)) bus ();
    execute_pipe #(.WIDTH(W), .REG_ADDR(R)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [1:0] exv);
        bus.alu_sel   = sel;
        bus.dato1     = a;
        bus.dato2     = b;
        bus.immediate = imm;
        bus.ex        = exv;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.dato1 = '0; bus.dato2 = '0; bus.immediate = '0;
        bus.pc_plus4 = '0; bus.rt = '0; bus.rd = '0; bus.ex = 2'b00; bus.m = 3'b000;
        bus.wb = 3'b000; bus.alu_sel = 4'b0000; bus.stall_in = 1'b0; bus.flush = 1'b0;
        step(); step();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_alu", 64'(bus.alu_result), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        step();

        // ADD 5 + imm 7, rt selected
        bus.rt = 5'd3; bus.rd = 5'd9; bus.m = 3'b101; bus.wb = 3'b011; bus.pc_plus4 = 32'h100;
        issue(4'b0010, 32'd5, 32'h55, 32'd7, 2'b10);
        chk("add_alu", 64'(bus.alu_result), 64'd12);
        chk("add_zero", 64'(bus.zero), 64'd0);
        chk("add_dir", 64'(bus.direccion), 64'd3);
        chk("add_valid", 64'(bus.out_valid), 64'd1);
        chk("add_m", 64'(bus.m_out), 64'd5);
        chk("add_wb", 64'(bus.wb_out), 64'd3);
        chk("add_dato2", 64'(bus.dato2_m), 64'h55);
        chk("add_br", 64'(bus.add_result), 64'h11C);
        step();
        chk("bubble_valid", 64'(bus.out_valid), 64'd0);

        issue(4'b0110, 32'd9, 32'd9, 32'd0, 2'b01);
        chk("sub_zero", 64'(bus.zero), 64'd1);
        chk("sub_dir_rd", 64'(bus.direccion), 64'd9);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00);
        chk("slt_alu", 64'(bus.alu_result), 64'd1);
        issue(4'b1100, 32'd0, 32'd0, 32'd0, 2'b00);
        chk("nor_alu", 64'(bus.alu_result), 64'hFFFF_FFFF);
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00);
        chk("and_alu", 64'(bus.alu_result), 64'h0000_F000);
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 2'b00);
        chk("or_alu", 64'(bus.alu_result), 64'h0000_FFF0);
        issue(4'b0101, 32'd3, 32'd4, 32'd0, 2'b00);
        chk("undef_alu", 64'(bus.alu_result), 64'd0);
        chk("undef_zero", 64'(bus.zero), 64'd1);
        bus.pc_plus4 = 32'h100;
        issue(4'b0010, 32'd0, 32'd0, 32'h4, 2'b10);
        chk("br_target", 64'(bus.add_result), 64'h110);
        chk("br_alu", 64'(bus.alu_result), 64'd4);

        // stall holds outputs, then flush kills control
        bus.m = 3'b111; bus.wb = 3'b111;
        issue(4'b0010, 32'd1, 32'd0, 32'd2, 2'b10);
        chk("pre_stall_alu", 64'(bus.alu_result), 64'd3);
        bus.stall_in = 1'b1;
        bus.alu_sel = 4'b0001; bus.dato1 = 32'hAAAA; bus.in_valid = 1'b1; bus.m = 3'b010;
        #1;
        chk("stall_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_alu", 64'(bus.alu_result), 64'd3);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_m", 64'(bus.m_out), 64'd7);
        end
        bus.flush = 1'b1;
        step();
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_m", 64'(bus.m_out), 64'd0);
        chk("flush_wb", 64'(bus.wb_out), 64'd0);
        chk("flush_hold_alu", 64'(bus.alu_result), 64'd3);
        bus.flush = 1'b0; bus.stall_in = 1'b0; bus.in_valid = 1'b0;
        step();
        chk("post_flush_valid", 64'(bus.out_valid), 64'd0);

`ifdef EXECUTE_PIPE_MULT_EN
        begin
            int bad;
            bus.rt = 5'd4; bus.m = 3'b010; bus.wb = 3'b001;
            issue(4'b1000, 32'd6, 32'd7, 32'd0, 2'b00);
            chk("mul_busy0", 64'(bus.busy), 64'd1);
            chk("mul_ready0", 64'(bus.in_ready), 64'd0);
            chk("mul_valid0", 64'(bus.out_valid), 64'd0);
            bad = 0;
            for (int i = 1; i < 32; i++) begin
                step();
                if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            end
            chk("mul_busy_window", 64'(bad), 64'd0);
            step();
            chk("mul_valid", 64'(bus.out_valid), 64'd1);
            chk("mul_alu", 64'(bus.alu_result), 64'd42);
            chk("mul_busy_end", 64'(bus.busy), 64'd0);
            chk("mul_dir", 64'(bus.direccion), 64'd4);
            chk("mul_m", 64'(bus.m_out), 64'd2);

            // completion under stall waits in WAIT
            issue(4'b1000, 32'd3, 32'd5, 32'd0, 2'b00);
            for (int i = 1; i < 32; i++) step();
            bus.stall_in = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("wait_busy", 64'(bus.busy), 64'd1);
                chk("wait_valid", 64'(bus.out_valid), 64'd0);
                chk("wait_alu_hold", 64'(bus.alu_result), 64'd42);
            end
            bus.stall_in = 1'b0;
            step();
            chk("wait_rel_valid", 64'(bus.out_valid), 64'd1);
            chk("wait_rel_alu", 64'(bus.alu_result), 64'd15);
            chk("wait_rel_busy", 64'(bus.busy), 64'd0);

            // reset during iteration 10
            issue(4'b1000, 32'd9, 32'd9, 32'd0, 2'b00);
            for (int i = 1; i < 10; i++) step();
            chk("mid_mul_busy", 64'(bus.busy), 64'd1);
        end
`else
        issue(4'b1000, 32'd6, 32'd7, 32'd0, 2'b00);
        chk("nomul_valid", 64'(bus.out_valid), 64'd1);
        chk("nomul_alu", 64'(bus.alu_result), 64'd0);
        chk("nomul_zero", 64'(bus.zero), 64'd1);
        chk("nomul_busy", 64'(bus.busy), 64'd0);
        issue(4'b0010, 32'd8, 32'd1, 32'd0, 2'b00);
        chk("pre_rst_alu", 64'(bus.alu_result), 64'd9);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_valid", 64'(bus.out_valid), 64'd0);
        chk("rst2_busy", 64'(bus.busy), 64'd0);
        chk("rst2_alu", 64'(bus.alu_result), 64'd0);
        chk("rst2_add", 64'(bus.add_result), 64'd0);
        chk("rst2_dato2", 64'(bus.dato2_m), 64'd0);
        chk("rst2_dir", 64'(bus.direccion), 64'd0);
        chk("rst2_mwb", 64'({bus.m_out, bus.wb_out}), 64'd0);
        chk("rst2_zero", 64'(bus.zero), 64'd0);
        chk("rst2_ready", 64'(bus.in_ready), 64'd1);
        issue(4'b0010, 32'd2, 32'd0, 32'd3, 2'b10);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_alu", 64'(bus.alu_result), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
